// File: rtl/best_1ofn_pipe_pkg.sv
// Shared pattern-finder constants and elaboration helpers for the best-1-of-N selector.
// Holds the default field widths, clamp-region bounds, the sort-source enum, and the
// clog2 / tree-shape functions used to size the pipeline.
package best_1ofn_pipe_pkg;

  localparam int unsigned DefNin    = 7;
  localparam int unsigned DefPatB   = 7;
  localparam int unsigned DefKeyB   = 5;
  localparam int unsigned DefOffsB  = 4;
  localparam int unsigned DefQltB   = 6;
  localparam int unsigned DefBndB   = 5;
  localparam int unsigned DefCarryB = 12;
  localparam int unsigned DefSplit  = 128;
  localparam int unsigned DefKeyMax = 223;

  typedef enum logic {
    SortPat = 1'b0,
    SortQlt = 1'b1
  } sort_sel_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Number of tuples present at tree level l (level 0 = the NIN registered channels).
  function automatic int unsigned lvl_cnt(input int unsigned n, input int unsigned l);
    return (n + (32'd1 << l) - 1) >> l;
  endfunction

  // Offset of level l inside the flattened tuple array.
  function automatic int unsigned lvl_base(input int unsigned n, input int unsigned l);
    int unsigned s;
    s = 0;
    for (int unsigned k = 0; k < l; k++) s += lvl_cnt(n, k);
    return s;
  endfunction

endpackage

// File: rtl/best_1of2_node.sv
// Registered 2-input compare/select node of the best-1-of-N tree.
// Input a always comes from the lower channel indices, so a wins every tie.
// Ports:
//   clock, global_reset         clock and synchronous active-high reset
//   a_live/a_key/a_idx/a_pay    lower-index candidate tuple
//   b_live/b_key/b_idx/b_pay    higher-index candidate tuple
//   y_live/y_key/y_idx/y_pay    registered winner tuple
module best_1of2_node #(
  parameter int unsigned KW = 6,
  parameter int unsigned IW = 3,
  parameter int unsigned PW = 39
) (
  input  logic          clock,
  input  logic          global_reset,
  input  logic          a_live,
  input  logic [KW-1:0] a_key,
  input  logic [IW-1:0] a_idx,
  input  logic [PW-1:0] a_pay,
  input  logic          b_live,
  input  logic [KW-1:0] b_key,
  input  logic [IW-1:0] b_idx,
  input  logic [PW-1:0] b_pay,
  output logic          y_live,
  output logic [KW-1:0] y_key,
  output logic [IW-1:0] y_idx,
  output logic [PW-1:0] y_pay
);

  logic b_wins;

  // b needs a strictly greater key to displace a live a.
  always_comb begin
    b_wins = b_live && (!a_live || (b_key > a_key));
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      y_live <= 1'b0;
      y_key  <= '0;
      y_idx  <= '0;
      y_pay  <= '0;
    end else if (b_wins) begin
      y_live <= b_live;
      y_key  <= b_key;
      y_idx  <= b_idx;
      y_pay  <= b_pay;
    end else begin
      y_live <= a_live;
      y_key  <= a_key;
      y_idx  <= a_idx;
      y_pay  <= a_pay;
    end
  end

endmodule

// File: rtl/best_1ofn_pipe.sv
// Pipelined best-1-of-N half-strip pattern selector.
// Stage 0 registers a per-channel sort key (qlt or pat[PATB-1:1]), a live bit and the
// payload; clog2(NIN) tree levels of best_1of2_node then reduce to one winner, and the
// region-clamped 1/8-strip subkey is formed from the root register. Latency is
// clog2(NIN)+1 cycles, one bus per cycle, no backpressure.
// Ports:
//   clock, global_reset              clock and synchronous active-high reset
//   in_vld, sort_on_qlt, in_mask     bus valid, sort-source select, per-channel enable
//   pat, key, offs, qlt, bend, carry packed per-channel fields, channel 0 in lsbs
//   out_vld, best_hit                result valid, some unmasked channel was present
//   best_pat/qlt/bend/carry          winner payload (0 when best_hit=0)
//   best_key, best_subkey            {winner index, key} and clamped 4*best_key+offs
module best_1ofn_pipe
  import best_1ofn_pipe_pkg::*;
#(
  parameter int unsigned NIN     = DefNin,
  parameter int unsigned PATB    = DefPatB,
  parameter int unsigned KEYB    = DefKeyB,
  parameter int unsigned OFFSB   = DefOffsB,
  parameter int unsigned QLTB    = DefQltB,
  parameter int unsigned BNDB    = DefBndB,
  parameter int unsigned CARRYB  = DefCarryB,
  parameter int unsigned SPLIT   = DefSplit,
  parameter int unsigned KEYMAX  = DefKeyMax,
  localparam int unsigned IDXB    = clog2(NIN),
  localparam int unsigned KEYXB   = IDXB + KEYB,
  localparam int unsigned SUBKEYB = KEYXB + 2
) (
  input  logic                  clock,
  input  logic                  global_reset,
  input  logic                  in_vld,
  input  logic                  sort_on_qlt,
  input  logic [NIN-1:0]        in_mask,
  input  logic [NIN*PATB-1:0]   pat,
  input  logic [NIN*KEYB-1:0]   key,
  input  logic [NIN*OFFSB-1:0]  offs,
  input  logic [NIN*QLTB-1:0]   qlt,
  input  logic [NIN*BNDB-1:0]   bend,
  input  logic [NIN*CARRYB-1:0] carry,
  output logic                  out_vld,
  output logic                  best_hit,
  output logic [PATB-1:0]       best_pat,
  output logic [QLTB-1:0]       best_qlt,
  output logic [BNDB-1:0]       best_bend,
  output logic [CARRYB-1:0]     best_carry,
  output logic [KEYXB-1:0]      best_key,
  output logic [SUBKEYB-1:0]    best_subkey
);

  localparam int unsigned DEPTH = IDXB;
  localparam int unsigned SKB   = max_u(QLTB, PATB - 1);
  localparam int unsigned PAYB  = PATB + KEYB + OFFSB + QLTB + BNDB + CARRYB;
  localparam int unsigned SW    = KEYXB + 3;
  localparam int unsigned TOT   = lvl_base(NIN, DEPTH + 1);
  localparam int unsigned ROOT  = lvl_base(NIN, DEPTH);

  // Payload layout, lsb first: carry, bend, qlt, offs, key, pat.
  localparam int unsigned BndO = CARRYB;
  localparam int unsigned QltO = BndO + BNDB;
  localparam int unsigned OffO = QltO + QLTB;
  localparam int unsigned KeyO = OffO + OFFSB;
  localparam int unsigned PatO = KeyO + KEYB;

  localparam logic signed [SW-1:0] Lo1 = SW'(4 * SPLIT);
  localparam logic signed [SW-1:0] Hi0 = SW'(4 * (SPLIT - 1) + 3);
  localparam logic signed [SW-1:0] Hi1 = SW'(4 * KEYMAX + 3);

  sort_sel_e sort_sel;
  assign sort_sel = sort_sel_e'(sort_on_qlt);

  // Stage 0 registers
  logic            s0_live [NIN];
  logic [SKB-1:0]  s0_key  [NIN];
  logic [PAYB-1:0] s0_pay  [NIN];
  logic [DEPTH:0]  vld_q;

  for (genvar i = 0; i < NIN; i++) begin : g_s0
    always_ff @(posedge clock) begin
      if (global_reset) begin
        s0_live[i] <= 1'b0;
        s0_key[i]  <= '0;
        s0_pay[i]  <= '0;
      end else begin
        s0_live[i] <= in_mask[i];
        s0_key[i]  <= (sort_sel == SortQlt) ? SKB'(qlt[i*QLTB +: QLTB])
                                            : SKB'(pat[i*PATB+1 +: PATB-1]);
        s0_pay[i]  <= {pat[i*PATB +: PATB], key[i*KEYB +: KEYB], offs[i*OFFSB +: OFFSB],
                       qlt[i*QLTB +: QLTB], bend[i*BNDB +: BNDB], carry[i*CARRYB +: CARRYB]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) vld_q <= '0;
    else              vld_q <= {vld_q[DEPTH-1:0], in_vld};
  end

  // Flattened tuples of every tree level; level 0 mirrors the stage-0 registers.
  logic            t_live [TOT];
  logic [SKB-1:0]  t_key  [TOT];
  logic [IDXB-1:0] t_idx  [TOT];
  logic [PAYB-1:0] t_pay  [TOT];

  for (genvar i = 0; i < NIN; i++) begin : g_l0
    assign t_live[i] = s0_live[i];
    assign t_key[i]  = s0_key[i];
    assign t_idx[i]  = IDXB'(i);
    assign t_pay[i]  = s0_pay[i];
  end

  for (genvar l = 1; l <= DEPTH; l++) begin : g_lvl
    localparam int unsigned NPrev = lvl_cnt(NIN, l - 1);
    localparam int unsigned NCur  = lvl_cnt(NIN, l);
    localparam int unsigned BPrev = lvl_base(NIN, l - 1);
    localparam int unsigned BCur  = lvl_base(NIN, l);

    for (genvar j = 0; j < NCur; j++) begin : g_node
      logic            b_live;
      logic [SKB-1:0]  b_key;
      logic [IDXB-1:0] b_idx;
      logic [PAYB-1:0] b_pay;

      if (2 * j + 1 < NPrev) begin : g_pair
        assign b_live = t_live[BPrev + 2 * j + 1];
        assign b_key  = t_key[BPrev + 2 * j + 1];
        assign b_idx  = t_idx[BPrev + 2 * j + 1];
        assign b_pay  = t_pay[BPrev + 2 * j + 1];
      end else begin : g_odd
        // Odd leftover: a dead partner turns the node into a plain register.
        assign b_live = 1'b0;
        assign b_key  = '0;
        assign b_idx  = '0;
        assign b_pay  = '0;
      end

      best_1of2_node #(
        .KW(SKB),
        .IW(IDXB),
        .PW(PAYB)
      ) u_node (
        .clock       (clock),
        .global_reset(global_reset),
        .a_live      (t_live[BPrev + 2 * j]),
        .a_key       (t_key[BPrev + 2 * j]),
        .a_idx       (t_idx[BPrev + 2 * j]),
        .a_pay       (t_pay[BPrev + 2 * j]),
        .b_live      (b_live),
        .b_key       (b_key),
        .b_idx       (b_idx),
        .b_pay       (b_pay),
        .y_live      (t_live[BCur + j]),
        .y_key       (t_key[BCur + j]),
        .y_idx       (t_idx[BCur + j]),
        .y_pay       (t_pay[BCur + j])
      );
    end
  end

  // Final stage: unpack the root winner, zeroing everything when nothing was live.
  logic [PAYB-1:0]  win_pay;
  logic [OFFSB-1:0] win_offs;

  assign out_vld = vld_q[DEPTH];

  always_comb begin
    best_hit   = t_live[ROOT];
    win_pay    = best_hit ? t_pay[ROOT] : '0;
    best_pat   = win_pay[PatO +: PATB];
    best_qlt   = win_pay[QltO +: QLTB];
    best_bend  = win_pay[BndO +: BNDB];
    best_carry = win_pay[CARRYB-1:0];
    win_offs   = win_pay[OffO +: OFFSB];
    best_key   = best_hit ? {t_idx[ROOT], win_pay[KeyO +: KEYB]} : '0;
  end

  logic signed [SW-1:0] sub_raw;
  logic signed [SW-1:0] reg_lo4;
  logic signed [SW-1:0] reg_hi4;
  logic                 in_hi_region;

  always_comb begin
    sub_raw      = $signed({1'b0, best_key, 2'b00}) +
                   $signed({{(SW-OFFSB){win_offs[OFFSB-1]}}, win_offs});
    in_hi_region = 32'(best_key) >= SPLIT;
    reg_lo4      = in_hi_region ? Lo1 : '0;
    reg_hi4      = in_hi_region ? Hi1 : Hi0;
    if (32'(best_key) > KEYMAX) begin
      best_subkey = SUBKEYB'(Hi1);
    end else if (sub_raw < reg_lo4) begin
      best_subkey = SUBKEYB'(reg_lo4);
    end else if (sub_raw > reg_hi4) begin
      best_subkey = SUBKEYB'(reg_hi4);
    end else begin
      best_subkey = SUBKEYB'(sub_raw);
    end
  end

endmodule

// File: tb/tb_best_1ofn_pipe.sv
// Directed bench for best_1ofn_pipe at its default parameters (NIN=7, latency 4).
module tb_best_1ofn_pipe;

  localparam int NIN     = 7;
  localparam int PATB    = 7;
  localparam int KEYB    = 5;
  localparam int OFFSB   = 4;
  localparam int QLTB    = 6;
  localparam int BNDB    = 5;
  localparam int CARRYB  = 12;
  localparam int KEYXB   = 8;
  localparam int SUBKEYB = 10;
  localparam int L       = 4;
  localparam int NBUS    = 20;
  localparam int OBSW    = 2 + PATB + QLTB + BNDB + CARRYB + KEYXB + SUBKEYB;

  logic                  clock = 1'b0;
  logic                  global_reset;
  logic                  in_vld;
  logic                  sort_on_qlt;
  logic [NIN-1:0]        in_mask;
  logic [NIN*PATB-1:0]   pat;
  logic [NIN*KEYB-1:0]   key;
  logic [NIN*OFFSB-1:0]  offs;
  logic [NIN*QLTB-1:0]   qlt;
  logic [NIN*BNDB-1:0]   bend;
  logic [NIN*CARRYB-1:0] carry;
  logic                  out_vld;
  logic                  best_hit;
  logic [PATB-1:0]       best_pat;
  logic [QLTB-1:0]       best_qlt;
  logic [BNDB-1:0]       best_bend;
  logic [CARRYB-1:0]     best_carry;
  logic [KEYXB-1:0]      best_key;
  logic [SUBKEYB-1:0]    best_subkey;
  logic [OBSW-1:0]       obs;

  always #5 clock = ~clock;

  best_1ofn_pipe #(.NIN(NIN)) dut (
    .clock       (clock),
    .global_reset(global_reset),
    .in_vld      (in_vld),
    .sort_on_qlt (sort_on_qlt),
    .in_mask     (in_mask),
    .pat         (pat),
    .key         (key),
    .offs        (offs),
    .qlt         (qlt),
    .bend        (bend),
    .carry       (carry),
    .out_vld     (out_vld),
    .best_hit    (best_hit),
    .best_pat    (best_pat),
    .best_qlt    (best_qlt),
    .best_bend   (best_bend),
    .best_carry  (best_carry),
    .best_key    (best_key),
    .best_subkey (best_subkey)
  );

  assign obs = {out_vld, best_hit, best_pat, best_qlt, best_bend, best_carry, best_key,
                best_subkey};

  int ch_pat[NIN], ch_key[NIN], ch_offs[NIN], ch_qlt[NIN], ch_bend[NIN], ch_carry[NIN];
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit vld;
    bit hit;
    int pat;
    int qlt;
    int bend;
    int carry;
    int key;
    int subkey;
  } exp_t;

  function automatic logic [OBSW-1:0] exp_vec(exp_t e);
    return {e.vld, e.hit, PATB'(e.pat), QLTB'(e.qlt), BNDB'(e.bend), CARRYB'(e.carry),
            KEYXB'(e.key), SUBKEYB'(e.subkey)};
  endfunction

  // Reference: linear scan for the lowest-index live channel with the maximum key.
  function automatic exp_t model(bit v, bit soq, logic [NIN-1:0] m);
    exp_t e;
    int best = -1;
    int bk = 0;
    int k, s, lo, hi;
    e.vld = v; e.hit = 0; e.pat = 0; e.qlt = 0; e.bend = 0; e.carry = 0;
    e.key = 0; e.subkey = 0;
    for (int i = 0; i < NIN; i++) begin
      if (m[i]) begin
        k = soq ? ch_qlt[i] : (ch_pat[i] >> 1);
        if (best < 0 || k > bk) begin
          best = i;
          bk = k;
        end
      end
    end
    if (best >= 0) begin
      e.hit = 1;
      e.pat = ch_pat[best];
      e.qlt = ch_qlt[best];
      e.bend = ch_bend[best];
      e.carry = ch_carry[best];
      e.key = best * 32 + ch_key[best];
      s = 4 * e.key + ch_offs[best];
      lo = (e.key < 128) ? 0 : 128;
      hi = (e.key < 128) ? 127 : 223;
      if (e.key > 223)          e.subkey = 895;
      else if (s < 4 * lo)      e.subkey = 4 * lo;
      else if (s > 4 * hi + 3)  e.subkey = 4 * hi + 3;
      else                      e.subkey = s;
    end
    return e;
  endfunction

  task automatic clear_chans();
    for (int i = 0; i < NIN; i++) begin
      ch_pat[i] = 0; ch_key[i] = 0; ch_offs[i] = 0;
      ch_qlt[i] = 0; ch_bend[i] = 0; ch_carry[i] = 0;
    end
  endtask

  task automatic rand_chans();
    for (int i = 0; i < NIN; i++) begin
      ch_pat[i] = int'($urandom_range(0, 15));
      ch_key[i] = int'($urandom_range(0, 31));
      ch_offs[i] = int'($urandom_range(0, 15)) - 8;
      ch_qlt[i] = int'($urandom_range(0, 7));
      ch_bend[i] = int'($urandom_range(0, 31));
      ch_carry[i] = int'($urandom_range(0, 4095));
    end
  endtask

  task automatic drive(input bit v, input bit soq, input logic [NIN-1:0] m);
    in_vld = v;
    sort_on_qlt = soq;
    in_mask = m;
    for (int i = 0; i < NIN; i++) begin
      pat[i*PATB +: PATB] = PATB'(ch_pat[i]);
      key[i*KEYB +: KEYB] = KEYB'(ch_key[i]);
      offs[i*OFFSB +: OFFSB] = OFFSB'(ch_offs[i]);
      qlt[i*QLTB +: QLTB] = QLTB'(ch_qlt[i]);
      bend[i*BNDB +: BNDB] = BNDB'(ch_bend[i]);
      carry[i*CARRYB +: CARRYB] = CARRYB'(ch_carry[i]);
    end
  endtask

  task automatic test_reset();
    global_reset = 1'b1;
    rand_chans();
    drive(1'b1, 1'b1, '1);
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_hold: got %h expected 0", obs);
      end
    end
    global_reset = 1'b0;
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_qlt_sort();
    int qt[NIN] = '{3, 9, 9, 1, 0, 2, 5};
    clear_chans();
    for (int i = 0; i < NIN; i++) begin
      ch_pat[i] = i; ch_key[i] = i + 10; ch_qlt[i] = qt[i];
      ch_bend[i] = i + 1; ch_carry[i] = 'h100 + i;
    end
    @(negedge clock);
    drive(1'b1, 1'b1, '1);
    @(negedge clock);
    in_vld = 1'b0;
    repeat (L - 2) @(negedge clock);
    checks++;
    if (out_vld !== 1'b0) begin
      errors++; $display("FAIL qlt_early_vld: got %b expected 0", out_vld);
    end
    @(negedge clock);
    checks++;
    if (out_vld !== 1'b1) begin errors++; $display("FAIL qlt_vld: got %b expected 1", out_vld); end
    checks++;
    if (best_hit !== 1'b1) begin errors++; $display("FAIL qlt_hit: got %b expected 1", best_hit); end
    checks++;
    if (best_key !== 8'd43) begin errors++; $display("FAIL qlt_key: got %0d expected 43", best_key); end
    checks++;
    if (best_qlt !== 6'd9) begin errors++; $display("FAIL qlt_qlt: got %0d expected 9", best_qlt); end
    checks++;
    if (best_pat !== 7'd1) begin errors++; $display("FAIL qlt_pat: got %0d expected 1", best_pat); end
    checks++;
    if (best_bend !== 5'd2) begin errors++; $display("FAIL qlt_bend: got %0d expected 2", best_bend); end
    checks++;
    if (best_carry !== 12'h101) begin
      errors++; $display("FAIL qlt_carry: got %h expected 101", best_carry);
    end
    checks++;
    if (best_subkey !== 10'd172) begin
      errors++; $display("FAIL qlt_subkey: got %0d expected 172", best_subkey);
    end
  endtask

  task automatic test_mask_partial();
    // Same channels as test_qlt_sort with ch1/ch2 masked: ch6 (qlt 5, key 16) wins.
    @(negedge clock);
    drive(1'b1, 1'b1, 7'b1111001);
    repeat (L) @(negedge clock);
    checks++;
    if (best_key !== 8'd208) begin errors++; $display("FAIL mask_key: got %0d expected 208", best_key); end
    checks++;
    if (best_qlt !== 6'd5) begin errors++; $display("FAIL mask_qlt: got %0d expected 5", best_qlt); end
    checks++;
    if (best_subkey !== 10'd832) begin
      errors++; $display("FAIL mask_subkey: got %0d expected 832", best_subkey);
    end
  endtask

  task automatic test_pat_tie();
    clear_chans();
    ch_pat[4] = 'h13; ch_key[4] = 7;
    ch_pat[5] = 'h12; ch_key[5] = 3; ch_qlt[5] = 40;
    @(negedge clock);
    drive(1'b1, 1'b0, '1);
    repeat (L) @(negedge clock);
    checks++;
    if (best_pat !== 7'h13) begin errors++; $display("FAIL tie_pat: got %h expected 13", best_pat); end
    checks++;
    if (best_key !== 8'd135) begin errors++; $display("FAIL tie_key: got %0d expected 135", best_key); end
    checks++;
    if (best_subkey !== 10'd540) begin
      errors++; $display("FAIL tie_subkey: got %0d expected 540", best_subkey);
    end
    // Same bus sorted on qlt: ch5 carries the only nonzero quality.
    drive(1'b1, 1'b1, '1);
    repeat (L) @(negedge clock);
    checks++;
    if (best_key !== 8'd163) begin errors++; $display("FAIL tie_qltmode_key: got %0d expected 163", best_key); end
  endtask

  task automatic test_mask_none();
    rand_chans();
    @(negedge clock);
    drive(1'b1, 1'b1, '0);
    repeat (L) @(negedge clock);
    checks++;
    if (out_vld !== 1'b1) begin errors++; $display("FAIL none_vld: got %b expected 1", out_vld); end
    checks++;
    if (best_hit !== 1'b0) begin errors++; $display("FAIL none_hit: got %b expected 0", best_hit); end
    checks++;
    if (best_key !== '0 || best_subkey !== '0) begin
      errors++; $display("FAIL none_key: got key %0d subkey %0d expected 0 0", best_key, best_subkey);
    end
    checks++;
    if ({best_pat, best_qlt, best_bend, best_carry} !== '0) begin
      errors++;
      $display("FAIL none_payload: got %h expected 0", {best_pat, best_qlt, best_bend, best_carry});
    end
  endtask

  task automatic test_clamp();
    int cidx[5] = '{0, 3, 4, 6, 1};
    int ckey[5] = '{0, 31, 0, 31, 18};
    int coff[5] = '{-3, 5, -2, 7, -2};
    int ekey[5] = '{0, 127, 128, 223, 50};
    int esub[5] = '{0, 511, 512, 895, 198};
    logic [NIN-1:0] m;
    for (int n = 0; n < 5; n++) begin
      clear_chans();
      ch_key[cidx[n]] = ckey[n];
      ch_offs[cidx[n]] = coff[n];
      ch_qlt[cidx[n]] = 10;
      m = '0;
      m[cidx[n]] = 1'b1;
      @(negedge clock);
      drive(1'b1, 1'b1, m);
      repeat (L) @(negedge clock);
      checks++;
      if (best_key !== KEYXB'(ekey[n])) begin
        errors++; $display("FAIL clamp%0d_key: got %0d expected %0d", n, best_key, ekey[n]);
      end
      checks++;
      if (best_subkey !== SUBKEYB'(esub[n])) begin
        errors++; $display("FAIL clamp%0d_subkey: got %0d expected %0d", n, best_subkey, esub[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[NBUS];
    logic [NIN-1:0] m;
    bit v, soq;
    for (int c = 0; c < NBUS + L; c++) begin
      @(negedge clock);
      if (c >= L) begin
        checks++;
        if (q[c-L].vld) begin
          if (obs !== exp_vec(q[c-L])) begin
            errors++;
            $display("FAIL stream%0d: got %h expected %h", c - L, obs, exp_vec(q[c-L]));
          end
        end else if (out_vld !== 1'b0) begin
          errors++;
          $display("FAIL stream%0d_vld: got %b expected 0", c - L, out_vld);
        end
      end
      if (c < NBUS) begin
        rand_chans();
        m = NIN'($urandom | $urandom);
        v = (c != 9);
        soq = c[0];
        q[c] = model(v, soq, m);
        drive(v, soq, m);
      end else begin
        drive(1'b0, 1'b0, '0);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      rand_chans();
      drive(1'b1, 1'b1, '1);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, '0);
    global_reset = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL midreset_zero: got %h expected 0", obs); end
    global_reset = 1'b0;
    for (int c = 0; c < L + 2; c++) begin
      @(negedge clock);
      checks++;
      if (out_vld !== 1'b0) begin
        errors++; $display("FAIL midreset_vld%0d: got %b expected 0", c, out_vld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_qlt_sort();
    test_mask_partial();
    test_pat_tie();
    test_mask_none();
    test_clamp();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
